// File: rtl/axi_line_fill.sv
// Fills one cache line with a single AXI4 INCR read burst: 18 cycles from start to done at full rate.
// Waits on ARREADY and RVALID as long as needed; RREADY is high for the whole data phase.
module axi_line_fill #(
    parameter int AXI_ADDR_W  = 32,
    parameter int AXI_DATA_W  = 32,
    parameter int AXI_ID_W    = 4,
    parameter int BLOCK_WIDTH = 512,
    parameter int AXI_ID      = 0
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_axi_read_start,
    input  logic [AXI_ADDR_W-1:0]  i_addr,
    output logic                   o_axi_read_done,
    output logic [BLOCK_WIDTH-1:0] o_data_block,
    output logic                   o_read_error,
    output logic [AXI_ID_W-1:0]    o_arid,
    output logic [AXI_ADDR_W-1:0]  o_araddr,
    output logic [7:0]             o_arlen,
    output logic [2:0]             o_arsize,
    output logic [1:0]             o_arburst,
    output logic                   o_arvalid,
    input  logic                   i_arready,
    input  logic [AXI_ID_W-1:0]    i_rid,
    input  logic [AXI_DATA_W-1:0]  i_rdata,
    input  logic [1:0]             i_rresp,
    input  logic                   i_rlast,
    input  logic                   i_rvalid,
    output logic                   o_rready
);

    localparam int BEATS = BLOCK_WIDTH / AXI_DATA_W;
    localparam int OFFS  = $clog2(BLOCK_WIDTH / 8);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [AXI_ADDR_W-1:0] LINE_MASK = {AXI_ADDR_W{1'b1}} << OFFS;
    localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AXI_ADDR_W-1:0]  addr_q, addr_d;
    logic [BLOCK_WIDTH-1:0] blk_q, blk_d;
    logic                   err_q, err_d;
    logic                   last_slot;
    logic                   beat_bad;

    assign o_arid    = AXI_ID_W'(AXI_ID);
    assign o_arlen   = 8'(BEATS - 1);
    assign o_arsize  = 3'($clog2(AXI_DATA_W / 8));
    assign o_arburst = 2'b01;

    assign o_arvalid       = (state_q == S_ADDR);
    assign o_rready        = (state_q == S_DATA);
    assign o_axi_read_done = (state_q == S_DONE);
    assign o_araddr        = addr_q;
    assign o_data_block    = blk_q;
    assign o_read_error    = err_q;

    assign last_slot = (cnt_q == LAST_CNT);
    assign beat_bad  = (i_rresp != 2'b00) || (i_rid != AXI_ID_W'(AXI_ID));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        blk_d   = blk_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_axi_read_start) begin
                    addr_d  = i_addr & LINE_MASK;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (i_arready) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (i_rvalid) begin
                    blk_d[cnt_q*AXI_DATA_W +: AXI_DATA_W] = i_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (beat_bad) begin
                        err_d = 1'b1;
                    end
                    // Whichever of RLAST or a full line comes first ends the burst; disagreement is an error.
                    if (i_rlast || last_slot) begin
                        state_d = S_DONE;
                        if (i_rlast != last_slot) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_arst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            blk_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            blk_q   <= blk_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_line_fill.sv
// Randomized and directed line fills against a word-array line model; a negedge monitor scores AR and done.
module tb_axi_line_fill;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int BW    = 512;
    localparam int BEATS = 16;

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic          i_axi_read_start;
    logic [AW-1:0] i_addr;
    logic          o_axi_read_done;
    logic [BW-1:0] o_data_block;
    logic          o_read_error;
    logic [IW-1:0] o_arid;
    logic [AW-1:0] o_araddr;
    logic [7:0]    o_arlen;
    logic [2:0]    o_arsize;
    logic [1:0]    o_arburst;
    logic          o_arvalid;
    logic          i_arready;
    logic [IW-1:0] i_rid;
    logic [DW-1:0] i_rdata;
    logic [1:0]    i_rresp;
    logic          i_rlast;
    logic          i_rvalid;
    logic          o_rready;

    always #5 i_clk = ~i_clk;

    axi_line_fill #(
        .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW), .BLOCK_WIDTH(BW), .AXI_ID(0)
    ) dut (
        .i_clk(i_clk), .i_arst(i_arst), .i_axi_read_start(i_axi_read_start), .i_addr(i_addr),
        .o_axi_read_done(o_axi_read_done), .o_data_block(o_data_block), .o_read_error(o_read_error),
        .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready), .i_rid(i_rid),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
        .o_rready(o_rready)
    );

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_req  = 0;
    int n_done_exp = 0;
    int ar_hs  = 0;
    int done_cnt = 0;

    logic [BW-1:0] exp_blk_q[$];
    bit            exp_err_q[$];
    logic [AW-1:0] exp_ar_q[$];
    logic [DW-1:0] model_blk[BEATS];

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_chk++;
        $display("FAIL %s: no DUT response within bound", name);
    endtask

    // Scoreboard monitor: AR handshakes and done pulses pop expectations queued by the driver.
    bit            pend = 1'b0;
    logic [AW-1:0] pend_addr;
    always @(negedge i_clk) begin
        if (pend && i_arst) begin
            check("arvalid_held", o_arvalid, 1);
            check("araddr_held", o_araddr, pend_addr);
        end
        pend      = o_arvalid && !i_arready && i_arst;
        pend_addr = o_araddr;
        if (o_arvalid && i_arready) begin
            ar_hs++;
            if (exp_ar_q.size() == 0) timeout("ar_unexpected");
            else begin
                check("araddr", o_araddr, exp_ar_q.pop_front());
                check("arlen", o_arlen, 15);
                check("arsize", o_arsize, 2);
                check("arburst", o_arburst, 1);
                check("arid", o_arid, 0);
            end
        end
        if (o_axi_read_done) begin
            done_cnt++;
            if (exp_blk_q.size() == 0) timeout("done_unexpected");
            else begin
                check("block", o_data_block, exp_blk_q.pop_front());
                check("read_error", o_read_error, exp_err_q.pop_front());
            end
        end
    end

    task automatic run_txn(input logic [AW-1:0] addr, input int ar_delay, input int gap_mode,
                           input int nsend, input bit rlast_flag, input int resp_beat,
                           input logic [1:0] resp_val, input int badid_beat,
                           input bit rnd_data, input bit chk_lat, input int rst_after);
        logic [DW-1:0] d[BEATS];
        logic [BW-1:0] eb;
        bit e;
        bit hs;
        int w;
        int c0;
        int nbeats;
        e = 1'b0;
        nbeats = (rst_after >= 0) ? rst_after + 1 : nsend;
        for (int k = 0; k < nbeats; k++) begin
            d[k] = rnd_data ? DW'($urandom) : DW'(32'hA000_0000 + k);
            if (rst_after < 0) model_blk[k] = d[k];
            if (k == resp_beat && resp_val != 2'b00) e = 1'b1;
            if (k == badid_beat) e = 1'b1;
        end
        if (nsend < BEATS || !rlast_flag) e = 1'b1;
        n_req++;
        exp_ar_q.push_back((addr / 64) * 64);
        if (rst_after < 0) begin
            for (int k = 0; k < BEATS; k++) eb[k*DW +: DW] = model_blk[k];
            exp_blk_q.push_back(eb);
            exp_err_q.push_back(e);
            n_done_exp++;
        end

        i_arready = (ar_delay == 0);
        i_axi_read_start = 1'b1;
        i_addr = addr;
        c0 = cyc;
        hs = 1'b0;
        w = 0;
        for (int t = 0; t < 40 && !hs; t++) begin
            @(negedge i_clk);
            if (o_arvalid && i_arready) hs = 1'b1;
            else if (o_arvalid) w++;
            @(posedge i_clk); #1;
            if (!hs) i_arready = (w >= ar_delay);
        end
        i_arready = 1'b0;
        if (!hs) begin
            timeout("ar_handshake");
            i_axi_read_start = 1'b0;
            return;
        end

        for (int k = 0; k < nbeats; k++) begin
            if ((gap_mode == 1 && k > 0) || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
                i_rvalid = 1'b0;
                @(posedge i_clk); #1;
            end
            i_rvalid = 1'b1;
            i_rdata  = d[k];
            i_rresp  = (k == resp_beat) ? resp_val : 2'b00;
            i_rid    = (k == badid_beat) ? 4'h5 : 4'h0;
            i_rlast  = rlast_flag && (k == nsend - 1);
            @(posedge i_clk); #1;
        end
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        i_rresp  = 2'b00;
        i_rid    = 4'h0;

        if (rst_after >= 0) begin
            i_arst = 1'b0;
            i_axi_read_start = 1'b0;
            @(posedge i_clk); #1;
            i_arst = 1'b1;
            for (int k = 0; k < BEATS; k++) model_blk[k] = '0;
            @(negedge i_clk);
            check("rst_arvalid", o_arvalid, 0);
            check("rst_rready", o_rready, 0);
            check("rst_done", o_axi_read_done, 0);
            check("rst_error", o_read_error, 0);
            check("rst_block", o_data_block, 0);
            @(negedge i_clk);
            check("rst_idle", o_arvalid, 0);
            @(posedge i_clk); #1;
            return;
        end

        @(negedge i_clk);
        check("done_after_last", o_axi_read_done, 1);
        if (chk_lat) check("latency", cyc - c0, 18);
        for (int t = 0; t < 40 && !o_axi_read_done; t++) @(negedge i_clk);
        if (!o_axi_read_done) timeout("done_wait");
        @(posedge i_clk); #1;
        i_axi_read_start = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge i_clk); #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_arst = 1'b0;
        i_axi_read_start = 1'b0;
        i_addr = '0;
        i_arready = 1'b0;
        i_rid = '0;
        i_rdata = '0;
        i_rresp = 2'b00;
        i_rlast = 1'b0;
        i_rvalid = 1'b0;
        for (int k = 0; k < BEATS; k++) model_blk[k] = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_arvalid", o_arvalid, 0);
        check("reset_rready", o_rready, 0);
        check("reset_done", o_axi_read_done, 0);
        check("reset_error", o_read_error, 0);
        check("reset_araddr", o_araddr, 0);
        check("reset_block", o_data_block, 0);
        @(posedge i_clk); #1;
        i_arst = 1'b1;
        @(posedge i_clk); #1;

        // addr, ar_delay, gap, nsend, rlast, resp_beat, resp, badid_beat, rnd, lat, rst_after
        run_txn(32'h0000_1234, 0, 0, 16, 1'b1, -1, 2'b00, -1, 1'b0, 1'b1, -1);
        run_txn(32'h0000_5678, 5, 1, 16, 1'b1, -1, 2'b00, -1, 1'b1, 1'b0, -1);
        run_txn(32'h0000_9ABC, 0, 0,  8, 1'b1, -1, 2'b00, -1, 1'b1, 1'b0, -1);
        run_txn(32'h0001_0040, 1, 0, 16, 1'b1,  3, 2'b10, -1, 1'b1, 1'b0, -1);
        run_txn(32'h0001_00FF, 0, 0, 16, 1'b1, -1, 2'b00, -1, 1'b1, 1'b1, -1);
        run_txn(32'h0002_0000, 0, 0, 16, 1'b0, -1, 2'b00, -1, 1'b1, 1'b0, -1);
        run_txn(32'h0002_0080, 2, 2, 16, 1'b1, -1, 2'b00,  9, 1'b1, 1'b0, -1);
        run_txn(32'h0003_0010, 0, 0, 16, 1'b1, -1, 2'b00, -1, 1'b1, 1'b0,  5);
        run_txn(32'h0003_0010, 0, 0, 16, 1'b1, -1, 2'b00, -1, 1'b1, 1'b1, -1);

        for (int i = 0; i < 20; i++) begin
            int kind;
            int ns;
            bit rl;
            int rb;
            int bb;
            logic [1:0] rv;
            kind = $urandom_range(0, 9);
            ns = 16;
            rl = 1'b1;
            if (kind == 0) ns = $urandom_range(1, 15);
            else if (kind == 1) rl = 1'b0;
            rb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
            rv = 2'($urandom_range(1, 3));
            bb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : -1;
            run_txn(AW'($urandom), $urandom_range(0, 3), 2, ns, rl, rb, rv, bb, 1'b1, 1'b0, -1);
        end

        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        check("ar_handshake_count", ar_hs, n_req);
        check("done_count", done_cnt, n_done_exp);
        check("pending_blocks", exp_blk_q.size(), 0);
        check("pending_ar", exp_ar_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
